iod_dly_responder: RTL
======================

Name: iod_dly_responder

Overview:
- Responder side of the RX bit-align training handshake; the soft IOD delay-line controller that the bit-align training sequencer drives.
- Consumes LOAD/MOVE/DIR/CLR_FLGS and maintains the tap-delay count.
- Produces sticky EARLY/LATE edge flags from three data samples (early, centre and late taps), and an OOR flag at delay-line limits.
- Sits between the training sequencer and the per-lane IOD sampling logic; also serves as the synthesizable stand-in for the hard IOD controller in lane-level simulation.

Parameters:
- TAP_WIDTH, 8, width of tap counter; max tap = 2^TAP_WIDTH-1.
- LOAD_VALUE, 0, tap value applied on LOAD and at reset.
- SETTLE_CNT_WIDTH, 3, post-move/post-load settle window = 2^SETTLE_CNT_WIDTH SCLK cycles.

Ports:
- SCLK in 1: fabric clock.
- RESETN in 1: asynchronous active-low reset.
- BIT_ALGN_LOAD in 1: level-sampled; reload tap to LOAD_VALUE.
- BIT_ALGN_MOVE in 1: one-cycle pulse; step tap by one.
- BIT_ALGN_DIR in 1: 1 = increment, 0 = decrement; sampled with MOVE.
- BIT_ALGN_CLR_FLGS in 1: clear EARLY/LATE/OOR flags.
- SMP_EARLY in 1: data sampled at early-offset tap.
- SMP_CENTER in 1: data sampled at current tap.
- SMP_LATE in 1: data sampled at late-offset tap.
- IOD_EARLY out 1: sticky; centre differs from early sample.
- IOD_LATE out 1: sticky; centre differs from late sample.
- IOD_OOR out 1: sticky; MOVE requested beyond tap limit.
- TAPDLY out TAP_WIDTH: current tap count.
- MOVE_BUSY out 1: high during settle window.
- MOVE_ERR out 1: one-cycle pulse when MOVE arrives while busy.

Behaviour:
- Reset values (async, RESETN low):
  - TAPDLY = LOAD_VALUE.
  - IOD_EARLY = IOD_LATE = IOD_OOR = 0, MOVE_ERR = 0.
  - MOVE_BUSY = 1, FSM = SETTLE, settle counter = 0.
- FSM states:
  - SETTLE: counter increments each cycle; at terminal count (2^SETTLE_CNT_WIDTH-1) go to ARMED next cycle. MOVE_BUSY = 1.
  - ARMED: MOVE_BUSY = 0; flag capture enabled.
- Command priority in any state: LOAD > MOVE.
- LOAD:
  - TAPDLY <= LOAD_VALUE, IOD_OOR <= 0, counter <= 0, FSM <= SETTLE.
  - A same-cycle MOVE is dropped silently.
- MOVE in ARMED:
  - DIR=1 and TAPDLY < max: TAPDLY+1.
  - DIR=0 and TAPDLY > 0: TAPDLY-1.
  - Either way, FSM <= SETTLE and counter <= 0 on the next edge.
  - At a limit (DIR=1 at max, or DIR=0 at 0): TAPDLY holds (no wrap), IOD_OOR <= 1, FSM stays ARMED.
- MOVE in SETTLE:
  - Ignored; TAPDLY unchanged.
  - MOVE_ERR high for exactly the next cycle.
  - Counter is not restarted.
- Flag capture (ARMED only, registered, 1-cycle latency):
  - IOD_EARLY <= IOD_EARLY | (SMP_EARLY ^ SMP_CENTER).
  - IOD_LATE <= IOD_LATE | (SMP_LATE ^ SMP_CENTER).
  - Samples taken in SETTLE are discarded.
- CLR_FLGS:
  - Clears IOD_EARLY, IOD_LATE and IOD_OOR on the next edge.
  - Clear beats a same-cycle set (capture or OOR event lost).
  - Does not affect TAPDLY or FSM.
- Sample inputs: assumed already synchronous to SCLK; no internal synchronizers.
- Reset mid-SETTLE: all state returns to reset values immediately; no partial move is retained.
- All outputs registered; no combinational input-to-output paths.

Decomposition:
- Shared package (iod_dly_pkg):
  - FSM state encoding (SETTLE, ARMED).
  - Default TAP_WIDTH and SETTLE_CNT_WIDTH constants, also reused by the training sequencer.
- One natural sub-module: iod_dly_flag_capture, holding the three-sample XOR compare and the sticky EARLY/LATE registers with clear priority.
- Tap counter, settle counter and FSM stay in the top module.

Test Plan:
- Reset: release RESETN, hold samples equal.
  - TAPDLY=0, MOVE_BUSY=1 for 8 cycles, then 0.
  - All flags 0.
- Increment: in ARMED, MOVE with DIR=1 five times, each after MOVE_BUSY falls.
  - TAPDLY=5; MOVE_BUSY high 8 cycles after each move.
  - MOVE_ERR never pulses.
- Limits and OOR:
  - At TAPDLY=0, MOVE DIR=0 -> TAPDLY stays 0, IOD_OOR=1, MOVE_BUSY stays 0.
  - CLR_FLGS -> IOD_OOR=0.
  - Drive to 255, then MOVE DIR=1 -> TAPDLY stays 255, OOR=1.
- Move while busy:
  - MOVE 2 cycles after a previous move -> TAPDLY unchanged, MOVE_ERR one-cycle pulse.
  - Settle window still ends 8 cycles after the first move.
- Flags:
  - In ARMED, SMP_EARLY=1, SMP_CENTER=0, SMP_LATE=0 for 1 cycle -> IOD_EARLY=1 next cycle and held; IOD_LATE=0.
  - Same stimulus during SETTLE -> no flag set.
  - CLR_FLGS coincident with a mismatch -> flag reads 0.
- Load and async reset:
  - At TAPDLY=40 with OOR=1, LOAD and MOVE together -> TAPDLY=0, OOR=0, SETTLE entered.
  - Assert RESETN low mid-SETTLE -> outputs reset asynchronously, without waiting for an SCLK edge.

Source files
------------

// File: rtl/iod_dly_pkg.sv
// Shared definitions for the IOD delay-line responder and the bit-align training sequencer.
package iod_dly_pkg;

  localparam int unsigned TAP_WIDTH_DEF        = 8;
  localparam int unsigned SETTLE_CNT_WIDTH_DEF = 3;

  typedef enum logic {
    ST_SETTLE = 1'b0,
    ST_ARMED  = 1'b1
  } dly_state_e;

endpackage : iod_dly_pkg

// File: rtl/iod_dly_flag_capture.sv
// Sticky EARLY/LATE edge flags from three data samples; clear wins over a same-cycle set.
module iod_dly_flag_capture (
  input  logic clk,
  input  logic rst_n,
  input  logic capture_en,
  input  logic clr,
  input  logic smp_early,
  input  logic smp_center,
  input  logic smp_late,
  output logic iod_early,
  output logic iod_late
);

  logic early_hit_c;
  logic late_hit_c;

  assign early_hit_c = capture_en & (smp_early ^ smp_center);
  assign late_hit_c  = capture_en & (smp_late ^ smp_center);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iod_early <= 1'b0;
      iod_late  <= 1'b0;
    end else if (clr) begin
      iod_early <= 1'b0;
      iod_late  <= 1'b0;
    end else begin
      iod_early <= iod_early | early_hit_c;
      iod_late  <= iod_late | late_hit_c;
    end
  end

endmodule : iod_dly_flag_capture

// File: rtl/iod_dly_responder.sv
// Soft IOD delay-line controller: tap counter, settle window and OOR/move-error reporting
// in response to the bit-align training sequencer.
module iod_dly_responder
  import iod_dly_pkg::*;
#(
  parameter int unsigned TAP_WIDTH        = TAP_WIDTH_DEF,
  parameter int unsigned LOAD_VALUE       = 0,
  parameter int unsigned SETTLE_CNT_WIDTH = SETTLE_CNT_WIDTH_DEF
) (
  input  logic                 SCLK,
  input  logic                 RESETN,
  input  logic                 BIT_ALGN_LOAD,
  input  logic                 BIT_ALGN_MOVE,
  input  logic                 BIT_ALGN_DIR,
  input  logic                 BIT_ALGN_CLR_FLGS,
  input  logic                 SMP_EARLY,
  input  logic                 SMP_CENTER,
  input  logic                 SMP_LATE,
  output logic                 IOD_EARLY,
  output logic                 IOD_LATE,
  output logic                 IOD_OOR,
  output logic [TAP_WIDTH-1:0] TAPDLY,
  output logic                 MOVE_BUSY,
  output logic                 MOVE_ERR
);

  localparam logic [TAP_WIDTH-1:0]        TAP_MAX     = '1;
  localparam logic [TAP_WIDTH-1:0]        TAP_LOAD    = TAP_WIDTH'(LOAD_VALUE);
  localparam logic [SETTLE_CNT_WIDTH-1:0] SETTLE_LAST = '1;

  dly_state_e                  state_q, state_d;
  logic [SETTLE_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [TAP_WIDTH-1:0]        tap_q, tap_d;
  logic                        oor_q, oor_d;
  logic                        err_q, err_d;
  logic                        busy_q, busy_d;
  logic                        at_limit_c;

  assign at_limit_c = BIT_ALGN_DIR ? (tap_q == TAP_MAX) : (tap_q == '0);

  // State register and all registered outputs
  always_ff @(posedge SCLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= ST_SETTLE;
      cnt_q   <= '0;
      tap_q   <= TAP_LOAD;
      oor_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tap_q   <= tap_d;
      oor_q   <= oor_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state: LOAD overrides any MOVE; CLR_FLGS overrides any OOR set
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tap_d   = tap_q;
    oor_d   = oor_q;
    err_d   = 1'b0;

    case (state_q)
      ST_SETTLE: begin
        cnt_d = cnt_q + SETTLE_CNT_WIDTH'(1);
        if (cnt_q == SETTLE_LAST) begin
          state_d = ST_ARMED;
        end
        if (BIT_ALGN_MOVE) begin
          err_d = 1'b1;
        end
      end
      ST_ARMED: begin
        if (BIT_ALGN_MOVE) begin
          if (at_limit_c) begin
            oor_d = 1'b1;
          end else begin
            tap_d   = BIT_ALGN_DIR ? (tap_q + TAP_WIDTH'(1)) : (tap_q - TAP_WIDTH'(1));
            state_d = ST_SETTLE;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = ST_SETTLE;
        cnt_d   = '0;
      end
    endcase

    if (BIT_ALGN_LOAD) begin
      tap_d   = TAP_LOAD;
      oor_d   = 1'b0;
      cnt_d   = '0;
      state_d = ST_SETTLE;
      err_d   = 1'b0;
    end

    if (BIT_ALGN_CLR_FLGS) begin
      oor_d = 1'b0;
    end

    busy_d = (state_d == ST_SETTLE);
  end

  iod_dly_flag_capture u_flag_capture (
    .clk        (SCLK),
    .rst_n      (RESETN),
    .capture_en (state_q == ST_ARMED),
    .clr        (BIT_ALGN_CLR_FLGS),
    .smp_early  (SMP_EARLY),
    .smp_center (SMP_CENTER),
    .smp_late   (SMP_LATE),
    .iod_early  (IOD_EARLY),
    .iod_late   (IOD_LATE)
  );

  assign TAPDLY    = tap_q;
  assign IOD_OOR   = oor_q;
  assign MOVE_ERR  = err_q;
  assign MOVE_BUSY = busy_q;

endmodule : iod_dly_responder
